// File: rtl/bulk_ep_in_pkt_if.sv
// Bus bundle for bulk_ep_in_pkt: AXI-Stream producer side, USB bulk IN side and fill level.
// The slave modport is the endpoint buffer; the master modport is the surrounding logic.
interface bulk_ep_in_pkt_if #(
  parameter int ABITS = 11
);
  logic             axis_tvalid_i;
  logic             axis_tready_o;
  logic             axis_tlast_i;
  logic [7:0]       axis_tdata_i;
  logic             bulk_ep_in_xfer_i;
  logic             bulk_ep_in_has_data_o;
  logic             bulk_ep_in_tvalid_o;
  logic             bulk_ep_in_tready_i;
  logic             bulk_ep_in_tlast_o;
  logic [7:0]       bulk_ep_in_tdata_o;
  logic [ABITS:0]   level_o;

  modport slave (
    input  axis_tvalid_i, axis_tlast_i, axis_tdata_i, bulk_ep_in_xfer_i, bulk_ep_in_tready_i,
    output axis_tready_o, bulk_ep_in_has_data_o, bulk_ep_in_tvalid_o, bulk_ep_in_tlast_o,
           bulk_ep_in_tdata_o, level_o
  );

  modport master (
    output axis_tvalid_i, axis_tlast_i, axis_tdata_i, bulk_ep_in_xfer_i, bulk_ep_in_tready_i,
    input  axis_tready_o, bulk_ep_in_has_data_o, bulk_ep_in_tvalid_o, bulk_ep_in_tlast_o,
           bulk_ep_in_tdata_o, level_o
  );
endinterface

// File: rtl/bulk_ep_in_pkt.sv
// Packet-aware bulk IN endpoint buffer: byte FIFO with per-byte frame-end flags, FWFT head register
// and MAX_PACKET splitting. Define BULK_EP_IN_ZLP_EN to append a zero-length packet on exact-boundary frames.
module bulk_ep_in_pkt #(
  parameter int ABITS      = 11,
  parameter int MAX_PACKET = 512
) (
  input  logic             clock,
  input  logic             reset,
  bulk_ep_in_pkt_if.slave  bus
);
  localparam int              DEPTH   = 1 << ABITS;
  localparam logic [ABITS:0]  DEPTH_L = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0]  MAXP_L  = (ABITS+1)'(MAX_PACKET);
  localparam logic [ABITS:0]  LASTIDX = (ABITS+1)'(MAX_PACKET - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [8:0]       mem [DEPTH];
  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   level_q, level_d, lasts_q, lasts_d, pkt_cnt_q, pkt_cnt_d;
  logic [8:0]       pf_q, pf_d;
  logic             pf_valid_q, pf_valid_d;
  logic             tready_q, has_data_q, has_data_d;
  logic [1:0]       state_q, state_d;
  logic             zlp_pending_q;
  logic             push, pop, pf_take, ram_nonempty, pf_from_ram, wr_en, tvalid, tlast, pkt_end;

  assign push         = bus.axis_tvalid_i & tready_q;
  assign tvalid       = (state_q == S_XFER) & pf_valid_q & ~zlp_pending_q;
  assign pop          = tvalid & bus.bulk_ep_in_tready_i;
  assign pkt_end      = (pkt_cnt_q == LASTIDX);
  assign tlast        = tvalid & (pf_q[8] | pkt_end);
  // level counts the head register too, so the RAM holds data only when level exceeds it
  assign ram_nonempty = level_q > (ABITS+1)'(pf_valid_q);
  assign pf_take      = ~pf_valid_q | pop;
  assign pf_from_ram  = pf_take & ram_nonempty;
  assign wr_en        = push & ~(pf_take & ~ram_nonempty);

  assign bus.axis_tready_o         = tready_q;
  assign bus.bulk_ep_in_has_data_o = has_data_q;
  assign bus.bulk_ep_in_tvalid_o   = tvalid;
  assign bus.bulk_ep_in_tlast_o    = tlast;
  assign bus.bulk_ep_in_tdata_o    = pf_q[7:0];
  assign bus.level_o               = level_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {bus.axis_tlast_i, bus.axis_tdata_i};
  end

  always_comb begin
    level_d    = level_q + (ABITS+1)'(push) - (ABITS+1)'(pop);
    lasts_d    = lasts_q + (ABITS+1)'(push & bus.axis_tlast_i) - (ABITS+1)'(pop & pf_q[8]);
    wr_ptr_d   = wr_ptr_q + ABITS'(wr_en);
    rd_ptr_d   = rd_ptr_q + ABITS'(pf_from_ram);
    pf_valid_d = pf_valid_q;
    pf_d       = pf_q;
    // head refill: RAM first, otherwise a beat arriving into an empty buffer bypasses the RAM
    if (pf_take) begin
      pf_valid_d = ram_nonempty | push;
      if (ram_nonempty)  pf_d = mem[rd_ptr_q];
      else if (push)     pf_d = {bus.axis_tlast_i, bus.axis_tdata_i};
    end
  end

  always_comb begin
    state_d    = state_q;
    has_data_d = has_data_q;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (level_q >= MAXP_L || lasts_q != '0 || zlp_pending_q) has_data_d = 1'b1;
        if (bus.bulk_ep_in_xfer_i) begin
          state_d   = S_XFER;
          pkt_cnt_d = '0;
        end
      end
      S_XFER: begin
        if (pop) pkt_cnt_d = pkt_cnt_q + (ABITS+1)'(1);
        if (!bus.bulk_ep_in_xfer_i) begin
          state_d    = S_IDLE;
          has_data_d = 1'b0;
        end else if (pop && tlast) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.bulk_ep_in_xfer_i) begin
          state_d    = S_IDLE;
          has_data_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      lasts_q    <= '0;
      pkt_cnt_q  <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      tready_q   <= 1'b0;
      has_data_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      lasts_q    <= lasts_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      tready_q   <= (level_d < DEPTH_L);
      has_data_q <= has_data_d;
      state_q    <= state_d;
    end
  end

`ifdef BULK_EP_IN_ZLP_EN
  logic zlp_pending_d, zlp_xfer_q, zlp_xfer_d;

  // zlp_xfer_q marks the transfer that was opened to carry the zero-length packet
  always_comb begin
    zlp_pending_d = zlp_pending_q;
    zlp_xfer_d    = zlp_xfer_q;
    if (state_q == S_IDLE && bus.bulk_ep_in_xfer_i) zlp_xfer_d = zlp_pending_q;
    if (pop && pf_q[8] && pkt_end)
      zlp_pending_d = 1'b1;
    else if (state_q != S_IDLE && !bus.bulk_ep_in_xfer_i && zlp_xfer_q)
      zlp_pending_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zlp_pending_q <= 1'b0;
      zlp_xfer_q    <= 1'b0;
    end else begin
      zlp_pending_q <= zlp_pending_d;
      zlp_xfer_q    <= zlp_xfer_d;
    end
  end
`else
  assign zlp_pending_q = 1'b0;
`endif
endmodule

// File: tb/tb_bulk_ep_in_pkt.sv
// Self-checking bench for bulk_ep_in_pkt (ABITS=8, MAX_PACKET=64) against a byte-queue packet model.
module tb_bulk_ep_in_pkt;
  localparam int ABITS = 8;
  localparam int MAXP  = 64;
`ifdef BULK_EP_IN_ZLP_EN
  localparam bit ZLP = 1'b1;
`else
  localparam bit ZLP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bulk_ep_in_pkt_if #(.ABITS(ABITS)) bus ();
  bulk_ep_in_pkt #(.ABITS(ABITS), .MAX_PACKET(MAXP)) dut (.clock(clk), .reset(rst), .bus(bus));

  int         n_checks = 0;
  int         n_err    = 0;
  logic [8:0] q[$];
  bit         zlp_m    = 1'b0;
  int         wval     = 0;

  typedef struct {
    int n_wr; int last_at; int limit; int exp_got; int exp_level; int exp_hd;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // bytes the next transfer should carry: up to a frame end or a full packet; zero for a pending ZLP
  function automatic int model_count();
    if (zlp_m) return 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i][8] || i + 1 == MAXP) return i + 1;
    return q.size();
  endfunction

  function automatic int model_hd();
    if (q.size() >= MAXP || zlp_m) return 1;
    foreach (q[i]) if (q[i][8]) return 1;
    return 0;
  endfunction

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic push_bytes(input int n, input int last_at);
    for (int i = 1; i <= n; i++) begin
      int guard;
      guard = 0;
      bus.axis_tvalid_i = 1'b1;
      bus.axis_tdata_i  = 8'(wval);
      bus.axis_tlast_i  = (i == last_at);
      while (!bus.axis_tready_o && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 1000) fail_now("push_tready");
      q.push_back({bus.axis_tlast_i, bus.axis_tdata_i});
      wval++;
      @(negedge clk);
    end
    bus.axis_tvalid_i = 1'b0;
    bus.axis_tlast_i  = 1'b0;
  endtask

  task automatic do_xfer(input int limit, input bit rnd, output int got);
    int exp_n, idle, iter;
    bit done, zlp_start;
    exp_n = model_count();
    if (exp_n > limit) exp_n = limit;
    zlp_start = zlp_m;
    got = 0; idle = 0; iter = 0; done = 1'b0;
    bus.bulk_ep_in_xfer_i   = 1'b1;
    bus.bulk_ep_in_tready_i = 1'b0;
    @(negedge clk);
    while (!done && got < limit && idle < 6 && iter < 2000) begin
      iter++;
      bus.bulk_ep_in_tready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.bulk_ep_in_tvalid_o) begin
        idle = 0;
        if (bus.bulk_ep_in_tready_i) begin
          logic [8:0] h;
          if (q.size() == 0) begin
            fail_now("xfer_overrun");
            done = 1'b1;
          end else begin
            h = q.pop_front();
            chk("xfer_data", int'(bus.bulk_ep_in_tdata_o), int'(h[7:0]));
            chk("xfer_tlast", int'(bus.bulk_ep_in_tlast_o), int'(h[8] || got == MAXP - 1));
            if (ZLP && h[8] && got == MAXP - 1) zlp_m = 1'b1;
            got++;
            if (h[8] || got == MAXP) done = 1'b1;
          end
        end
      end else begin
        idle++;
      end
      @(negedge clk);
    end
    if (iter >= 2000) fail_now("xfer_cycles");
    bus.bulk_ep_in_tready_i = 1'b0;
    bus.bulk_ep_in_xfer_i   = 1'b0;
    @(negedge clk);
    if (zlp_start) zlp_m = 1'b0;
    chk("xfer_count", got, exp_n);
    chk("hd_after_xfer", int'(bus.bulk_ep_in_has_data_o), 0);
    $display("xfer: limit=%0d bytes=%0d level=%0d", limit, got, bus.level_o);
  endtask

  task automatic drain(input bit rnd);
    int g;
    for (int k = 0; k < 20 && model_hd() != 0; k++) begin
      settle();
      chk("hd_before_xfer", int'(bus.bulk_ep_in_has_data_o), 1);
      do_xfer(1000, rnd, g);
    end
    settle();
    chk("drain_level", int'(bus.level_o), q.size());
    chk("drain_hd", int'(bus.bulk_ep_in_has_data_o), model_hd());
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.axis_tvalid_i       = 1'b0;
    bus.axis_tlast_i        = 1'b0;
    bus.axis_tdata_i        = 8'h00;
    bus.bulk_ep_in_xfer_i   = 1'b0;
    bus.bulk_ep_in_tready_i = 1'b0;

    vecs[0] = '{n_wr: 10, last_at: 10, limit: 999, exp_got: 10, exp_level: 0,  exp_hd: 0};
    vecs[1] = '{n_wr: 65, last_at: 65, limit: 999, exp_got: 64, exp_level: 1,  exp_hd: 1};
    vecs[2] = '{n_wr: 0,  last_at: 0,  limit: 999, exp_got: 1,  exp_level: 0,  exp_hd: 0};
    vecs[3] = '{n_wr: 64, last_at: 64, limit: 20,  exp_got: 20, exp_level: 44, exp_hd: 1};
    vecs[4] = '{n_wr: 0,  last_at: 0,  limit: 999, exp_got: 44, exp_level: 0,  exp_hd: 0};
    vecs[5] = '{n_wr: 1,  last_at: 1,  limit: 999, exp_got: 1,  exp_level: 0,  exp_hd: 0};
    vecs[6] = '{n_wr: 70, last_at: 0,  limit: 999, exp_got: 64, exp_level: 6,  exp_hd: 0};
    vecs[7] = '{n_wr: 2,  last_at: 2,  limit: 999, exp_got: 8,  exp_level: 0,  exp_hd: 0};

    // reset values, then tready one edge after release
    repeat (2) @(negedge clk);
    chk("rst_tready", int'(bus.axis_tready_o), 0);
    chk("rst_level", int'(bus.level_o), 0);
    chk("rst_hd", int'(bus.bulk_ep_in_has_data_o), 0);
    chk("rst_tvalid", int'(bus.bulk_ep_in_tvalid_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", int'(bus.axis_tready_o), 1);

    // 10-byte frame: has_data one edge after the level update
    push_bytes(9, 0);
    settle();
    chk("hd_no_last", int'(bus.bulk_ep_in_has_data_o), 0);
    push_bytes(1, 1);
    chk("hd_edge_n", int'(bus.bulk_ep_in_has_data_o), 0);
    chk("level_10", int'(bus.level_o), 10);
    @(negedge clk);
    chk("hd_edge_n1", int'(bus.bulk_ep_in_has_data_o), 1);
    do_xfer(1000, 1'b0, g);
    chk("frame10_got", g, 10);
    chk("frame10_level", int'(bus.level_o), 0);

    for (int i = 0; i < 8; i++) begin
      push_bytes(vecs[i].n_wr, vecs[i].last_at);
      settle();
      do_xfer(vecs[i].limit, 1'b0, g);
      chk("vec_got", g, vecs[i].exp_got);
      settle();
      chk("vec_level", int'(bus.level_o), vecs[i].exp_level);
      chk("vec_hd", int'(bus.bulk_ep_in_has_data_o), vecs[i].exp_hd);
    end

    // 200 unframed bytes: has_data on the 64th, three full packets, 8 left
    push_bytes(63, 0);
    settle();
    chk("hd_63", int'(bus.bulk_ep_in_has_data_o), 0);
    push_bytes(1, 0);
    chk("hd_64_n", int'(bus.bulk_ep_in_has_data_o), 0);
    @(negedge clk);
    chk("hd_64_n1", int'(bus.bulk_ep_in_has_data_o), 1);
    push_bytes(136, 0);
    for (int k = 0; k < 3; k++) begin
      settle();
      do_xfer(1000, 1'b0, g);
      chk("pkt64_got", g, 64);
    end
    settle();
    chk("rem8_level", int'(bus.level_o), 8);
    chk("rem8_hd", int'(bus.bulk_ep_in_has_data_o), 0);
    push_bytes(1, 1);
    drain(1'b0);

    // 128-byte frame ending on a packet boundary
    push_bytes(128, 128);
    settle();
    do_xfer(1000, 1'b0, g);
    chk("f128_p1", g, 64);
    settle();
    do_xfer(1000, 1'b0, g);
    chk("f128_p2", g, 64);
    settle();
    chk("f128_zlp_hd", int'(bus.bulk_ep_in_has_data_o), int'(ZLP));
    drain(1'b0);
    chk("f128_level", int'(bus.level_o), 0);

    // full buffer, single-byte delivery, then streaming at constant level
    push_bytes(256, 0);
    chk("full_tready", int'(bus.axis_tready_o), 0);
    chk("full_level", int'(bus.level_o), 256);
    do_xfer(1, 1'b0, g);
    chk("full_one_got", g, 1);
    chk("full_tready_back", int'(bus.axis_tready_o), 1);
    chk("full_level_255", int'(bus.level_o), 255);
    settle();
    bus.bulk_ep_in_xfer_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      logic [8:0] h;
      bus.axis_tvalid_i       = 1'b1;
      bus.axis_tdata_i        = 8'(wval);
      bus.axis_tlast_i        = 1'b0;
      bus.bulk_ep_in_tready_i = 1'b1;
      chk("stream_level", int'(bus.level_o), 255);
      chk("stream_tready", int'(bus.axis_tready_o), 1);
      chk("stream_tvalid", int'(bus.bulk_ep_in_tvalid_o), 1);
      h = q.pop_front();
      chk("stream_data", int'(bus.bulk_ep_in_tdata_o), int'(h[7:0]));
      q.push_back({1'b0, bus.axis_tdata_i});
      wval++;
      @(negedge clk);
    end
    bus.axis_tvalid_i       = 1'b0;
    bus.bulk_ep_in_tready_i = 1'b0;
    bus.bulk_ep_in_xfer_i   = 1'b0;
    @(negedge clk);
    chk("stream_level_end", int'(bus.level_o), 255);
    drain(1'b0);
    push_bytes(1, 1);
    drain(1'b0);

    // asynchronous reset in the middle of a transfer
    push_bytes(64, 64);
    settle();
    bus.bulk_ep_in_xfer_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_tvalid", int'(bus.bulk_ep_in_tvalid_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", int'(bus.bulk_ep_in_tvalid_o), 0);
    chk("arst_hd", int'(bus.bulk_ep_in_has_data_o), 0);
    chk("arst_tready", int'(bus.axis_tready_o), 0);
    chk("arst_level", int'(bus.level_o), 0);
    q.delete();
    zlp_m = 1'b0;
    bus.bulk_ep_in_xfer_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_release_tready", int'(bus.axis_tready_o), 1);
    push_bytes(5, 5);
    settle();
    do_xfer(1000, 1'b0, g);
    chk("after_rst_got", g, 5);

    // random frames drained with random sink stalls
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 150);
      push_bytes(n, ($urandom_range(0, 1) != 0) ? n : 0);
      drain(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/bulk_ep_in_pkt.md
# bulk_ep_in_pkt

Single-clock, packet-aware bulk IN endpoint buffer between an 8-bit AXI-Stream producer and the USB device core's bulk IN port. It stores bytes together with their frame-end markers. It splits the stream into USB packets of at most `MAX_PACKET` bytes and raises `bulk_ep_in_has_data_o` only when a full packet or a frame end is buffered. It optionally appends a zero-length packet when a frame ends exactly on a packet boundary.

## Interface
Parameters:
- `ABITS`, 11: FIFO depth is 2^ABITS entries of 9 bits (data + last flag).
- `MAX_PACKET`, 512: maximum bulk packet payload in bytes; 1 ≤ MAX_PACKET ≤ 2^ABITS.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `axis_tvalid_i`  in  1  producer beat valid.
- `axis_tready_o`  out  1  buffer not full.
- `axis_tlast_i`  in  1  frame end marker.
- `axis_tdata_i`  in  8  producer byte.
- `bulk_ep_in_xfer_i`  in  1  USB core IN transaction active.
- `bulk_ep_in_has_data_o`  out  1  endpoint ready to answer IN (otherwise NAK).
- `bulk_ep_in_tvalid_o`  out  1  byte valid to USB core.
- `bulk_ep_in_tready_i`  in  1  USB core accepts byte.
- `bulk_ep_in_tlast_o`  out  1  last byte of this USB packet.
- `bulk_ep_in_tdata_o`  out  8  byte to USB core.
- `level_o`  out  ABITS+1  bytes buffered, including the prefetch register.

## Operation
- Write on `axis_tvalid_i & axis_tready_o`. The entry stores the byte and `axis_tlast_i`. `axis_tready_o = (level < 2^ABITS)`.
- `lasts` counter (ABITS+1 bits): +1 on an accepted tlast beat, −1 on a delivered byte whose last flag is set; unchanged when both happen.
- A first-word-fall-through prefetch register holds the head entry. The read side delivers on `bulk_ep_in_tvalid_o & bulk_ep_in_tready_i`.
- `pkt_cnt` counts bytes delivered in the current packet. It clears when entering XFER.
- `bulk_ep_in_tlast_o = tvalid_o & (head.last | pkt_cnt == MAX_PACKET-1)`.
- State machine:
  - IDLE: `has_data <= 1` when `level ≥ MAX_PACKET | lasts != 0 | zlp_pending`. On `xfer_i=1`, go to XFER.
  - XFER: `tvalid_o = prefetch_valid & ~zlp_pending`. A byte delivered with tlast_o goes to DONE. If `xfer_i=0` (host abort), go to IDLE and clear has_data. Undelivered bytes stay buffered, and the next packet restarts at pkt_cnt=0.
  - DONE: tvalid_o=0. On `xfer_i=0`, go to IDLE, clear has_data, and clear zlp_pending if this transfer was the ZLP.
- When `xfer_i` rises with nothing deliverable, tvalid_o stays 0 and the USB core ends the packet (zero bytes).
- There is no retransmit buffer: bytes handshaken to the USB core are consumed.

## Timing
- All outputs reset to 0: axis_tready_o=0 during reset and 1 on the first edge after release. level_o=0, state IDLE, lasts=0, zlp_pending=0. An asynchronous assert mid-transfer discards all buffered data immediately.
- Write→level_o: a beat accepted at edge N is counted in level_o after edge N. has_data_o is registered and asserts after edge N+1 when the beat satisfies its condition.
- tvalid_o asserts combinationally in the cycle after the edge that samples `xfer_i=1`, provided the prefetch register is valid.
- Sustained throughput is 1 byte/clock while tready_i=1, including across the FIFO→prefetch boundary.
- A simultaneous write and read leaves level unchanged. When full, tready_o rises the cycle after one byte is delivered.
- Pointers wrap modulo 2^ABITS.

## Configuration
- `BULK_EP_IN_ZLP_EN` defined: when a delivered byte has both its last flag set and `pkt_cnt == MAX_PACKET-1`, set `zlp_pending`. The next transfer sends zero bytes (tvalid_o held 0), after which zlp_pending clears. has_data_o asserts for that transfer even with an empty FIFO.
- Undefined: zlp_pending is tied to 0 and no zero-length packet is produced.

## Test plan
(ABITS=8, MAX_PACKET=64)
- 10 bytes 0x00..0x09 with tlast on 0x09, accepted at edge N → has_data_o=1 after N+1. One xfer delivers 10 bytes with tlast_o on 0x09. After xfer_i falls, has_data_o=0 and level_o=0.
- 200 bytes without tlast → has_data_o rises after the 64th byte. Three transfers each deliver 64 bytes with tlast_o on byte 64, and level_o ends at 8 with has_data_o=0.
- 128 bytes with tlast on byte 128, `BULK_EP_IN_ZLP_EN` defined → two 64-byte packets, then a third xfer with zero bytes, then has_data_o=0. Undefined → only two packets, and has_data_o=0 after the second.
- 256 bytes written with no xfer → tready_o=0 and level_o=256. A one-byte xfer delivery → tready_o=1 on the next cycle. A simultaneous write and read during full streaming holds level_o constant.
- Abort: xfer_i drops after 20 of 64 bytes → level_o=44. The next xfer delivers bytes 21..64 with tlast_o on byte 64.
- Assert reset mid-XFER → tvalid_o, has_data_o, tready_o and level_o are 0 without a clock edge. After release, a fresh 5-byte frame transfers correctly.
